// File: rtl/versat_master_pkg.sv
// Shared op codes, FSM state encoding and response width for the Versat access master.
package versat_master_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;

    localparam int RESP_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RUN,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/versat_cmd_fifo.sv
// Synchronous command FIFO with registered count; read data is the head entry, zero-latency.
// Push while full and pop while empty are ignored; push and pop together are both performed.
module versat_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dat   = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

endmodule

// File: rtl/versat_access_master.sv
// Versat unit-bus initiator: buffers host commands, issues one access or run each, returns one response.
// Pop-to-valid one cycle; holds requests until ready/done; VERSAT_MASTER_TIMEOUT_EN adds a per-op timeout.
module versat_access_master
    import versat_master_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = RESP_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err,
    output logic                valid,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    input  logic                ready,
    input  logic [DATA_W-1:0]   rdata,
    output logic                run,
    input  logic                done,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = 2 + ADDR_W + DATA_W + STRB_W;

    logic [CMD_W-1:0]  w_fifo_out;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [STRB_W-1:0] w_wstrb;
    logic [DATA_W-1:0] w_cnt_inc;

    state_t            r_state;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_is_read;
    logic              r_run;
    logic [DATA_W-1:0] r_cnt;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;

`ifdef VERSAT_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_resp_err;
    logic              w_tmo_hit;
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign resp_err  = r_resp_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT;
    assign resp_err         = 1'b0;
`endif

    // Commands are only popped from IDLE, so a pending response blocks the queue.
    assign w_pop = (r_state == ST_IDLE) && !w_empty;
    assign {w_op, w_addr, w_wdata, w_wstrb} = w_fifo_out;
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    versat_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (cmd_valid),
        .i_dat   ({cmd_op, cmd_addr, cmd_wdata, cmd_wstrb}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_is_read    <= 1'b0;
            r_run        <= 1'b0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
`ifdef VERSAT_MASTER_TIMEOUT_EN
            r_tmo        <= '0;
            r_resp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_addr    <= w_addr;
                        r_wdata   <= w_wdata;
                        r_is_read <= (w_op == OP_READ);
`ifdef VERSAT_MASTER_TIMEOUT_EN
                        r_tmo      <= '0;
                        r_resp_err <= 1'b0;
`endif
                        // Reserved op 11 shares the run path with op 10.
                        if (w_op[1]) begin
                            r_run   <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            r_valid <= 1'b1;
                            r_wstrb <= (w_op == OP_READ) ? '0 :
                                       ((w_wstrb == '0) ? '1 : w_wstrb);
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
`ifdef VERSAT_MASTER_TIMEOUT_EN
                    r_tmo <= r_tmo + 1'b1;
`endif
                    if (ready) begin
                        r_valid      <= 1'b0;
                        r_resp_data  <= r_is_read ? rdata : '0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
`ifdef VERSAT_MASTER_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_valid      <= 1'b0;
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
`endif
                end
                ST_RUN: begin
                    r_run   <= 1'b0;
                    r_cnt   <= '0;
`ifdef VERSAT_MASTER_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // r_cnt lags the cycles since the run pulse by one, so report the increment.
                    r_cnt <= w_cnt_inc;
`ifdef VERSAT_MASTER_TIMEOUT_EN
                    r_tmo <= r_tmo + 1'b1;
`endif
                    if (done) begin
                        r_resp_data  <= w_cnt_inc;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
`ifdef VERSAT_MASTER_TIMEOUT_EN
                    else if (w_tmo_hit) begin
                        r_resp_data  <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = !w_full;
    assign busy       = !w_empty || (r_state != ST_IDLE);
    assign valid      = r_valid;
    assign addr       = r_addr;
    assign wstrb      = r_wstrb;
    assign wdata      = r_wdata;
    assign run        = r_run;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_versat_access_master.sv
// Bench for versat_access_master: timestamp-based reference model plus directed literal checks.
module tb_versat_access_master;
    import versat_master_pkg::*;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
`ifdef VERSAT_MASTER_TIMEOUT_EN
    localparam int TMO    = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 1024;
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk, rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          resp_valid, resp_ready, resp_err;
    logic [DW-1:0] resp_data;
    logic          valid, ready, run, done, busy;
    logic [AW-1:0] addr;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata, rdata;

    versat_access_master #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .ready(ready), .rdata(rdata), .run(run), .done(done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- responder ----------------
    bit            rnd = 1'b0;
    int            rsp_delay = 0, done_delay = 1, vcnt = 0, kcnt = 0;
    bit            waiting = 1'b0;
    logic [DW-1:0] fixed_rdata = '0;

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            ready = 1'b0; done = 1'b0; waiting = 1'b0; vcnt = 0;
        end else begin
            if (valid) begin
                ready = (vcnt >= rsp_delay);
                vcnt++;
            end else begin
                ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                vcnt = 0;
                if (rnd) rsp_delay = $urandom_range(0, 4);
            end
            rdata = rnd ? DW'($urandom) : fixed_rdata;
            if (run) begin
                if (rnd) done_delay = $urandom_range(1, 6);
                waiting = 1'b1; kcnt = 0;
                done = 1'b1;  // must be ignored in the run cycle
            end else if (waiting) begin
                kcnt++;
                done = (kcnt >= done_delay);
                if (done) waiting = 1'b0;
            end else begin
                done = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            acc;
    } cmd_t;

    cmd_t          q[$];
    cmd_t          cur, nc;
    bit            cur_act = 1'b0, cur_end = 1'b0, cur_err = 1'b0;
    int            cur_start = 0, free_cyc = 0, cyc = 0;
    logic [DW-1:0] cur_data;
    logic          e_valid, e_run, e_rv;
    logic [SW-1:0] e_wstrb;

    int            cur_vcnt = 0, v_cycles = 0, run_pulses = 0, resp_cnt = 0;
    logic [SW-1:0] last_wstrb;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_resp;
    logic          last_err;

    always @(negedge clk) begin
        if (!rst) begin
            q.delete(); cur_act = 1'b0; free_cyc = 0; cyc = 0; cur_vcnt = 0;
        end else begin
            if (!cur_act && q.size() > 0 && q[0].acc + 2 <= cyc && free_cyc <= cyc) begin
                cur = q.pop_front();
                cur_act = 1'b1; cur_end = 1'b0; cur_err = 1'b0; cur_start = cyc;
            end
            e_valid = cur_act && !cur.op[1] && !cur_end;
            e_run   = cur_act && cur.op[1] && (cyc == cur_start);
            e_rv    = cur_act && cur_end;
            e_wstrb = (cur.op == OP_READ) ? '0 : ((cur.wstrb == '0) ? '1 : cur.wstrb);

            chk("valid", valid, e_valid);
            chk("run", run, e_run);
            chk("resp_valid", resp_valid, e_rv);
            chk("cmd_ready", cmd_ready, q.size() < DEPTH);
            chk("busy", busy, (q.size() > 0) || cur_act);
            if (e_valid) begin
                chk("addr", addr, cur.addr);
                chk("wstrb", wstrb, e_wstrb);
                if (cur.op == OP_WRITE) chk("wdata", wdata, cur.wdata);
            end
            if (e_rv) begin
                chk("resp_data", resp_data, cur_data);
                chk("resp_err", resp_err, cur_err);
            end

            if (e_valid) begin
                if (ready) begin
                    cur_end = 1'b1; cur_data = (cur.op == OP_READ) ? rdata : '0;
                end else if (TMO_EN && (cyc - cur_start + 1 >= TMO)) begin
                    cur_end = 1'b1; cur_data = '0; cur_err = 1'b1;
                end
            end
            if (cur_act && cur.op[1] && !cur_end && cyc > cur_start) begin
                if (done) begin
                    cur_end = 1'b1; cur_data = DW'(cyc - cur_start);
                end else if (TMO_EN && (cyc - cur_start >= TMO)) begin
                    cur_end = 1'b1; cur_data = '0; cur_err = 1'b1;
                end
            end
            if (e_rv && resp_ready) begin
                cur_act = 1'b0; free_cyc = cyc + 2;
            end
            if (cmd_valid && q.size() < DEPTH) begin
                nc.op = cmd_op; nc.addr = cmd_addr; nc.wdata = cmd_wdata;
                nc.wstrb = cmd_wstrb; nc.acc = cyc;
                q.push_back(nc);
            end

            if (valid) begin
                cur_vcnt++; last_wstrb = wstrb; last_addr = addr;
            end else if (cur_vcnt != 0) begin
                v_cycles = cur_vcnt; cur_vcnt = 0;
            end
            if (run) run_pulses++;
            if (resp_valid && resp_ready) begin
                resp_cnt++; last_resp = resp_data; last_err = resp_err;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input int base);
        for (int i = 0; i < 300; i++) begin
            if (resp_cnt > base) break;
            step();
        end
        chk(name, resp_cnt > base, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 600; i++) begin
            if (!busy) break;
            step();
        end
        chk(name, busy, 0);
    endtask

    int base, rbase;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; resp_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", valid, 0);
        chk("rst_run", run, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_resp_err", resp_err, 0);
        rst = 1'b1;
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        resp_ready = 1'b1;

        // write, ready in the second valid cycle
        rsp_delay = 1; base = resp_cnt;
        push(OP_WRITE, 2'd3, 32'hDEADBEEF, 4'hF);
        wait_resp("wr_wait", base);
        chk("wr_valid_cycles", v_cycles, 2);
        chk("wr_wstrb", last_wstrb, 4'hF);
        chk("wr_addr", last_addr, 2'd3);
        chk("wr_resp_data", last_resp, 0);
        chk("wr_resp_err", last_err, 0);

        // read with immediate ready
        rsp_delay = 0; fixed_rdata = 32'h12345678; base = resp_cnt;
        push(OP_READ, 2'd1, 32'h0, 4'h0);
        wait_resp("rd_wait", base);
        chk("rd_resp_data", last_resp, 32'h12345678);
        chk("rd_wstrb", last_wstrb, 4'h0);
        chk("rd_valid_cycles", v_cycles, 1);

        // run, done first high 7 cycles after the pulse
        done_delay = 7; base = resp_cnt; rbase = run_pulses;
        push(OP_RUN, 2'd0, 32'h0, 4'h0);
        wait_resp("run_wait", base);
        chk("run_pulses", run_pulses - rbase, 1);
        chk("run_resp_data", last_resp, 7);

        // zero strobes on a write drive all-ones; reserved op acts as run
        base = resp_cnt;
        push(OP_WRITE, 2'd2, 32'hCAFE0001, 4'h0);
        wait_resp("wr0_wait", base);
        chk("wr0_wstrb", last_wstrb, 4'hF);
        done_delay = 1; base = resp_cnt; rbase = run_pulses;
        push(2'b11, 2'd0, 32'h0, 4'h0);
        wait_resp("op3_wait", base);
        chk("op3_run_pulses", run_pulses - rbase, 1);
        chk("op3_resp_data", last_resp, 1);

        // fill the FIFO behind a held response
        resp_ready = 1'b0; done_delay = 2; base = resp_cnt;
        push(OP_RUN, 2'd0, 32'h0, 4'h0);
        for (int i = 0; i < 40 && !resp_valid; i++) step();
        chk("full_hold_resp", resp_valid, 1);
        for (int i = 0; i < 4; i++) push(2'(i & 1), 2'(i), 32'h100 + i, 4'h3);
        chk("full_cmd_ready", cmd_ready, 0);
        push(OP_WRITE, 2'd0, 32'hBAD, 4'hF);
        chk("full_busy", busy, 1);
        resp_ready = 1'b1;
        wait_idle("full_drain");
        chk("full_resp_count", resp_cnt - base, 5);

`ifdef VERSAT_MASTER_TIMEOUT_EN
        rsp_delay = 1000; base = resp_cnt;
        push(OP_READ, 2'd1, 32'h0, 4'h0);
        wait_resp("tmo_wait", base);
        chk("tmo_valid_cycles", v_cycles, TMO);
        chk("tmo_resp_err", last_err, 1);
        chk("tmo_resp_data", last_resp, 0);
        rsp_delay = 0;
`endif

        // randomized traffic
        rnd = 1'b1; base = resp_cnt;
        for (int i = 0; i < 500; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_op    = 2'($urandom);
            cmd_addr  = AW'($urandom);
            cmd_wdata = DW'($urandom);
            cmd_wstrb = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        cmd_valid = 1'b0; resp_ready = 1'b1;
        wait_idle("rand_drain");
        chk("rand_resp_seen", resp_cnt > base + 20, 1);
        rnd = 1'b0; rsp_delay = 0;
        repeat (3) step();

        // reset in the middle of an access
        rsp_delay = 1000;
        push(OP_READ, 2'd2, 32'h0, 4'h0);
        for (int i = 0; i < 10 && !valid; i++) step();
        chk("mid_valid_before", valid, 1);
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_run", run, 0);
        step();
        rst = 1'b1;
        #1;
        chk("mid_rel_cmd_ready", cmd_ready, 1);
        chk("mid_rel_valid", valid, 0);
        rsp_delay = 0; fixed_rdata = 32'h0BADF00D; base = resp_cnt;
        step();
        push(OP_READ, 2'd0, 32'h0, 4'h0);
        wait_resp("post_rst_wait", base);
        chk("post_rst_resp_data", last_resp, 32'h0BADF00D);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
